// File: rtl/parity_stream_gen_check_pkg.sv
// Shared constants and the per-group parity helper for the parity stream unit.
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  // Widest group the helper accepts; narrower slices are zero-extended,
  // which leaves the XOR unchanged.
  localparam int MAX_GROUP_W = 64;

  function automatic logic group_parity(input logic [MAX_GROUP_W-1:0] slice,
                                        input logic                   odd);
    logic x;
    x = ^slice;
    return (odd == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/parity_stream_gen_check_if.sv
// Handshake, configuration and statistics bundle of the parity stream unit.
interface parity_stream_gen_check_if #(
  parameter int DATA_W  = 8,
  parameter int GROUP_W = 4,
  parameter int CNT_W   = 8
);
  localparam int NG = DATA_W / GROUP_W;

  logic              cfg_odd;
  logic              cfg_chk;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [NG-1:0]     in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NG-1:0]     out_par;
  logic              out_err;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_cnt;
  logic              clr_err;

  modport master (
    output cfg_odd, cfg_chk, in_valid, in_data, in_par, out_ready, clr_err,
    input  in_ready, out_valid, out_data, out_par, out_err, err_sticky, err_cnt
  );

  modport slave (
    input  cfg_odd, cfg_chk, in_valid, in_data, in_par, out_ready, clr_err,
    output in_ready, out_valid, out_data, out_par, out_err, err_sticky, err_cnt
  );

endinterface

// File: rtl/parity_stream_gen_check_calc.sv
// Combinational per-group parity of a data word (odd or even selectable).
module parity_group_calc
  import parity_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GROUP_W = 4,
  parameter int NG      = DATA_W / GROUP_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_odd,
  output logic [NG-1:0]     o_par
);

  for (genvar gi = 0; gi < NG; gi++) begin : g_group
    logic [MAX_GROUP_W-1:0] w_slice;
    assign w_slice   = MAX_GROUP_W'(i_data[gi*GROUP_W +: GROUP_W]);
    assign o_par[gi] = group_parity(w_slice, i_odd);
  end

endmodule

// File: rtl/parity_stream_gen_check.sv
// Registered parity generate/check stage with valid/ready handshake and
// saturating error statistics.
module parity_stream_gen_check
  import parity_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GROUP_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  parity_stream_gen_check_if.slave  bus
);

  localparam int NG = DATA_W / GROUP_W;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [NG-1:0]     r_out_par;
  logic              r_out_err;
  logic              r_err_sticky;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [NG-1:0]     w_par;
  logic [NG-1:0]     w_mm;
  logic              w_word_err;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_err_fire;
  logic [CNT_W-1:0]  w_cnt_base;

  parity_group_calc #(
    .DATA_W  (DATA_W),
    .GROUP_W (GROUP_W),
    .NG      (NG)
  ) u_calc (
    .i_data (bus.in_data),
    .i_odd  (bus.cfg_odd),
    .o_par  (w_par)
  );

  assign w_mm       = w_par ^ bus.in_par;
  assign w_word_err = (bus.cfg_chk == MODE_CHK) && (|w_mm);

  // Ready looks through the output register so a draining word frees the slot
  // in the same cycle.
  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_err_fire = w_in_fire & w_word_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_par   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data;
      r_out_par   <= w_par;
      r_out_err   <= w_word_err;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // A clear in the same cycle as a new error wipes the old count first.
  assign w_cnt_base = bus.clr_err ? '0 : r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_err_fire) begin
      r_err_cnt    <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + 1'b1;
      r_err_sticky <= 1'b1;
    end else if (bus.clr_err) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_par    = r_out_par;
  assign bus.out_err    = r_out_err;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_parity_stream_gen_check.sv
// Self-checking bench: two instances (8-bit and 2-bit error counters) share
// stimulus and are compared against a queue-based reference model.
module tb_parity_stream_gen_check;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] p;
    logic       e;
  } word_t;

  logic clk;
  logic rst_n;

  parity_stream_gen_check_if #(.DATA_W(8), .GROUP_W(4), .CNT_W(8)) bus  ();
  parity_stream_gen_check_if #(.DATA_W(8), .GROUP_W(4), .CNT_W(2)) bus2 ();

  parity_stream_gen_check #(.DATA_W(8), .GROUP_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  parity_stream_gen_check #(.DATA_W(8), .GROUP_W(4), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.cfg_odd   = bus.cfg_odd;
  assign bus2.cfg_chk   = bus.cfg_chk;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.in_par    = bus.in_par;
  assign bus2.out_ready = bus.out_ready;
  assign bus2.clr_err   = bus.clr_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  word_t q[$];
  int    m_cnt8;
  int    m_cnt2;
  logic  m_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference parity: count the ones in each nibble.
  function automatic logic [1:0] model_par(input logic [7:0] d, input logic odd);
    logic [1:0] r;
    for (int g = 0; g < 2; g++) begin
      int ones;
      ones = $countones(d[g*4 +: 4]);
      r[g] = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt8   = 0;
    m_cnt2   = 0;
    m_sticky = 1'b0;
  endtask

  // One clock: check pre-edge outputs, advance the model, check statistics after the edge.
  task automatic cycle();
    logic  exp_ready, in_fire, out_fire, err;
    word_t w;
    #1;
    exp_ready = (q.size() == 0) || bus.out_ready;
    chk("in_ready", bus.in_ready, exp_ready);
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("out_valid2", bus2.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", bus.out_data, q[0].d);
      chk("out_par", bus.out_par, q[0].p);
      chk("out_err", bus.out_err, q[0].e);
      chk("out_data2", bus2.out_data, q[0].d);
    end
    in_fire  = bus.in_valid && exp_ready;
    out_fire = (q.size() != 0) && bus.out_ready;
    w.d = bus.in_data;
    w.p = model_par(bus.in_data, bus.cfg_odd);
    w.e = bus.cfg_chk && (w.p != bus.in_par);
    err = in_fire && w.e;
    if (out_fire) void'(q.pop_front());
    if (in_fire) q.push_back(w);
    if (bus.clr_err) begin
      m_cnt8   = 0;
      m_cnt2   = 0;
      m_sticky = 1'b0;
    end
    if (err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
      m_sticky = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("err_cnt", bus.err_cnt, m_cnt8);
    chk("err_cnt2", bus2.err_cnt, m_cnt2);
    chk("err_sticky", bus.err_sticky, m_sticky);
    chk("err_sticky2", bus2.err_sticky, m_sticky);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] p,
                       input logic odd, input logic chkm, input logic rdy, input logic clr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_par    = p;
    bus.cfg_odd   = odd;
    bus.cfg_chk   = chkm;
    bus.out_ready = rdy;
    bus.clr_err   = clr;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 8'h00, 2'b00, 0, 0, 1, 0);
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_par", bus.out_par, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_err_sticky", bus.err_sticky, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Generate, odd, C3
    drive(1, 8'hC3, 2'b00, 1, 0, 1, 0);
    cycle();
    drive(0, 8'h00, 2'b00, 1, 0, 1, 0);
    chk("gen_odd_valid", bus.out_valid, 1);
    chk("gen_odd_data", bus.out_data, 8'hC3);
    chk("gen_odd_par", bus.out_par, 2'b11);
    chk("gen_odd_err", bus.out_err, 0);
    cycle();

    // Generate, even then odd, B1
    drive(1, 8'hB1, 2'b00, 0, 0, 1, 0);
    cycle();
    chk("gen_even_par", bus.out_par, 2'b11);
    drive(1, 8'hB1, 2'b00, 1, 0, 1, 0);
    cycle();
    chk("gen_odd_b1_par", bus.out_par, 2'b00);

    // Check mode, odd, C3 with bad then good parity
    drive(1, 8'hC3, 2'b10, 1, 1, 1, 0);
    cycle();
    chk("chk_bad_err", bus.out_err, 1);
    chk("chk_bad_cnt", bus.err_cnt, 1);
    chk("chk_bad_sticky", bus.err_sticky, 1);
    drive(1, 8'hC3, 2'b11, 1, 1, 1, 0);
    cycle();
    chk("chk_good_err", bus.out_err, 0);
    chk("chk_good_cnt", bus.err_cnt, 1);
    drive(0, 8'h00, 2'b00, 1, 0, 1, 0);
    cycle();

    // Backpressure: first word captured, following words refused
    drive(1, 8'h11, 2'b00, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h20 + 8'(i), 2'b00, 0, 0, 0, 0);
      cycle();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_data", bus.out_data, 8'h11);
    end
    drive(1, 8'h5A, 2'b00, 0, 0, 1, 0);
    cycle();
    chk("bp_release_data", bus.out_data, 8'h5A);
    drive(1, 8'h6B, 2'b00, 1, 0, 1, 0);
    cycle();
    drive(0, 8'h00, 2'b00, 0, 0, 1, 0);
    cycle();
    cycle();

    // Saturation of the 2-bit counter, then clear coinciding with an error
    drive(0, 8'h00, 2'b00, 0, 0, 1, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'hC3, 2'b10, 1, 1, 1, 0);
      cycle();
    end
    chk("sat_cnt2", bus2.err_cnt, 3);
    chk("sat_cnt8", bus.err_cnt, 5);
    drive(1, 8'hC3, 2'b01, 1, 1, 1, 1);
    cycle();
    chk("clr_err_cnt", bus.err_cnt, 1);
    chk("clr_err_cnt2", bus2.err_cnt, 1);
    chk("clr_err_sticky", bus.err_sticky, 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
      cycle();
    end

    // Mid-stream asynchronous reset with a word held
    drive(1, 8'hC3, 2'b00, 1, 1, 0, 0);
    cycle();
    chk("pre_rst_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_cnt", bus.err_cnt, 0);
    chk("async_rst_sticky", bus.err_sticky, 0);
    drive(1, 8'h77, 2'b00, 1, 1, 1, 0);
    @(posedge clk);
    #1;
    chk("in_rst_no_xfer", bus.out_valid, 0);
    rst_n = 1'b1;
    model_reset();
    drive(0, 8'h00, 2'b00, 0, 0, 1, 0);
    #1;
    chk("rst_release_ready", bus.in_ready, 1);
    cycle();
    drive(1, 8'h3C, 2'b00, 0, 0, 1, 0);
    cycle();
    drive(0, 8'h00, 2'b00, 0, 0, 1, 0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_stream_gen_check.md
Name: parity_stream_gen_check

Overview:
Parametrised, registered parity unit for the datapath. It generalises the fixed 4-bit odd-parity generator in four ways:
- data width is a parameter;
- data is split into several parity groups;
- odd or even parity is chosen at run time;
- it can generate parity or check received parity, and keeps error statistics.

Words stream through on a valid/ready handshake with a one-cycle registered latency. The block sits between a word source and a link or storage stage.

Parameters:
DATA_W, 8, data word width in bits; must be a multiple of GROUP_W.
GROUP_W, 4, bits covered by each parity bit; NG = DATA_W/GROUP_W groups.
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
cfg_odd  input  1  1 = odd parity, 0 = even parity; sampled on the input transfer.
cfg_chk  input  1  1 = check mode, 0 = generate mode; sampled on the input transfer.
in_valid  input  1  input word valid.
in_ready  output  1  block can accept a word.
in_data  input  DATA_W  data word.
in_par  input  NG  received parity bits, one per group; used only in check mode.
out_valid  output  1  output word valid.
out_ready  input  1  downstream accepts the word.
out_data  output  DATA_W  registered copy of in_data.
out_par  output  NG  computed parity, one bit per group.
out_err  output  1  word failed the parity check; always 0 in generate mode.
err_sticky  output  1  set by any checked error; cleared only by clr_err or reset.
err_cnt  output  CNT_W  count of erroneous words; saturates at all-ones.
clr_err  input  1  synchronous clear of err_sticky and err_cnt.

Behaviour:
- Group parity: group g covers in_data[g*GROUP_W +: GROUP_W].
  - x = XOR of the group's bits.
  - par[g] = ~x when cfg_odd=1, and x when cfg_odd=0.
  - Result: total ones in the group plus its parity bit is odd (cfg_odd=1) or even (cfg_odd=0).
- Mismatch vector: mm = par ^ in_par. Word error = cfg_chk & (|mm).
- Input transfer occurs when in_valid & in_ready. On transfer, the following are registered on the next clk edge:
  - in_data into out_data;
  - par into out_par;
  - word error into out_err;
  - out_valid is set to 1.
  - Latency is exactly 1 cycle.
- in_ready = ~out_valid | out_ready. It is combinational, so a word can be accepted in the same cycle the held word drains; back-to-back throughput is 1 word/cycle.
- Output transfer occurs when out_valid & out_ready. If there is no simultaneous input transfer, out_valid goes to 0 next cycle.
- Stall: while out_valid=1 and out_ready=0, out_data, out_par and out_err hold stable and in_ready=0.
- Configuration changes between transfers affect only later words. A word already registered is never recomputed.
- Error statistics update on the input-transfer cycle of an erroneous word.
  - err_cnt increments by 1 unless it is already all-ones; it saturates and never wraps.
  - err_sticky is set to 1.
- clr_err: err_cnt and err_sticky go to 0 next cycle.
  - If clr_err coincides with an erroneous transfer, clear is applied first and then the new error counts: err_cnt=1, err_sticky=1.
- Reset (asynchronous assert, synchronous deassert handled upstream) drives all of these to 0:
  - out_valid, out_data, out_par, out_err, err_sticky, err_cnt.
- in_ready is 1 from the first cycle after reset.
- Reset mid-stream discards the held word, and no transfer completes during reset.

Decomposition:
- Shared package parity_pkg holds:
  - the mode constants PAR_EVEN=0 and PAR_ODD=1;
  - the mode constants MODE_GEN=0 and MODE_CHK=1;
  - a helper function for the parity of a GROUP_W-bit slice.
- One combinational sub-module, parity_group_calc, takes (data, cfg_odd) and produces NG parity bits.
- The top level holds the handshake register stage and the error statistics.

Test Plan (DATA_W=8, GROUP_W=4 unless stated):
- Generate, odd, in_data=8'hC3 -> one cycle later out_valid=1, out_data=8'hC3, out_par=2'b11, out_err=0.
- Generate, even, in_data=8'hB1 -> out_par=2'b11. Same word with odd -> out_par=2'b00.
- Check, odd, in_data=8'hC3, in_par=2'b10 -> out_err=1, err_cnt=1, err_sticky=1. Next word in_par=2'b11 -> out_err=0, err_cnt stays 1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and changing data -> in_ready=0, output holds the first word; release -> words emerge in order with none lost or duplicated.
- With CNT_W=2, 5 erroneous words -> err_cnt=3. Then clr_err together with a 6th erroneous word -> err_cnt=1, err_sticky=1.
- Assert rst_n=0 mid-stream while out_valid=1 -> out_valid and err_cnt are 0 immediately, without waiting for clk; after release, in_ready=1.
